data_path: RTL

- Datapath of the K-and-S processor; sits directly downstream of control_unit and consumes its strobes.
- Holds the program counter, instruction register, register file, ALU and flags register.
- Decodes the instruction register into decoded_instruction and returns registered ALU flags to the control unit.
- Drives the address and write data of the single-port RAM; ram_write_enable goes from control_unit straight to the RAM, not through this block.

---
 rtl/k_and_s_pkg.sv | 71 +++++++
 rtl/data_path_alu.sv | 47 ++++
 rtl/data_path.sv | 108 ++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// K-and-S shared types: instruction classes, opcodes, ALU op codes
// and the IR decoder used by data_path.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_HALT,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_BNZERO
  } decoded_instruction_type;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_HALT   = 8'hFF;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_BRANCH = 8'h01;
  localparam logic [7:0] OPC_BZERO  = 8'h02;
  localparam logic [7:0] OPC_BNEG   = 8'h03;
  localparam logic [7:0] OPC_BOV    = 8'h04;
  localparam logic [7:0] OPC_BNOV   = 8'h05;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_BNZERO = 8'h0B;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  function automatic decoded_instruction_type
    decode(input logic [15:0] ir);
    decoded_instruction_type d;
    d = I_NOP;
    case (ir[15:8])
      OPC_HALT:   d = (ir == 16'hFFFF) ? I_HALT : I_NOP;
      OPC_LOAD:   d = I_LOAD;
      OPC_STORE:  d = I_STORE;
      OPC_MOVE:   d = I_MOVE;
      OPC_ADD:    d = I_ADD;
      OPC_SUB:    d = I_SUB;
      OPC_AND:    d = I_AND;
      OPC_OR:     d = I_OR;
      OPC_BRANCH: d = I_BRANCH;
      OPC_BZERO:  d = I_BZERO;
      OPC_BNEG:   d = I_BNEG;
      OPC_BOV:    d = I_BOV;
      OPC_BNOV:   d = I_BNOV;
      OPC_BNNEG:  d = I_BNNEG;
      OPC_BNZERO: d = I_BNZERO;
      default:    d = I_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: OR/ADD/SUB/AND with zero, neg, carry/borrow
// and two's-complement overflow. Ports: a, b, operation -> result, flags.
module alu
  import k_and_s_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   operation,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         neg,
  output logic         uov,
  output logic         sov
);

  logic [W:0] wide;

  always_comb begin
    result = '0;
    wide   = '0;
    uov    = 1'b0;
    sov    = 1'b0;
    case (operation)
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        uov    = wide[W];
        sov    = (a[W-1] == b[W-1]) &&
                 (result[W-1] != a[W-1]);
      end
      OP_SUB: begin
        result = a - b;
        uov    = (a < b);
        sov    = (a[W-1] != b[W-1]) &&
                 (result[W-1] != a[W-1]);
      end
      default: result = '0;
    endcase
    zero = (result == '0);
    neg  = result[W-1];
  end

endmodule

// File: rtl/data_path.sv
// K-and-S datapath: PC, IR, 4x register file, ALU and flags.
// In: control strobes, data_in. Out: decode, flags, ram_addr, data_out.
module data_path
  import k_and_s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic [DATA_WIDTH-1:0]   data_in
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] regs_q [4];
  logic zero_q, neg_q, uov_q, sov_q;

  decoded_instruction_type dec;
  logic [DATA_WIDTH-1:0] op_a, op_b, alu_res, wdata;
  logic [1:0] dst;
  logic a_zero, a_neg, a_uov, a_sov;
  logic is_move;

  assign dec = decode(ir_q);
  assign is_move = (dec == I_MOVE);
  assign decoded_instruction = dec;

  assign ram_addr = addr_sel ? ir_q[ADDR_WIDTH-1:0] : pc_q;
  assign data_out = regs_q[ir_q[6:5]];

  // MOVE reuses the ALU: rs on a, zero on b, so OR passes it through
  always_comb begin
    op_a = regs_q[ir_q[3:2]];
    op_b = regs_q[ir_q[1:0]];
    if (is_move) begin
      op_a = regs_q[ir_q[1:0]];
      op_b = '0;
    end
  end

  alu #(.W(DATA_WIDTH)) u_alu (
    .a         (op_a),
    .b         (op_b),
    .operation (operation),
    .result    (alu_res),
    .zero      (a_zero),
    .neg       (a_neg),
    .uov       (a_uov),
    .sov       (a_sov)
  );

  always_comb begin
    dst = ir_q[5:4];
    unique case (1'b1)
      (dec == I_LOAD): dst = ir_q[6:5];
      is_move:         dst = ir_q[3:2];
      default:         dst = ir_q[5:4];
    endcase
  end

  assign wdata = c_sel ? alu_res : data_in;
  assign pc_d  = branch ? ir_q[ADDR_WIDTH-1:0]
                        : pc_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ir_q   <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      if (pc_enable) pc_q <= pc_d;
      if (ir_enable) ir_q <= data_in;
      if (write_reg_enable) regs_q[dst] <= wdata;
      if (flags_reg_enable) begin
        zero_q <= a_zero;
        neg_q  <= a_neg;
        uov_q  <= a_uov & ~is_move;
        sov_q  <= a_sov & ~is_move;
      end
    end
  end

  assign zero_op           = zero_q;
  assign neg_op            = neg_q;
  assign unsigned_overflow = uov_q;
  assign signed_overflow   = sov_q;

endmodule
